// File: rtl/ram_req_arbiter.sv
// Startup-gated two-client PSRAM request arbiter with per-transfer watchdog (150 MHz RAM domain).
// Define RAM_ARB_BUS_PRIORITY_EN for fixed bus-port priority; otherwise round-robin.
module ram_req_arbiter #(
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned STARTUP_CYCLES = 22500,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  output logic              ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_be,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic [1:0]        bus_be,
  output logic              bus_ack,
  output logic              bus_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SC_W = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_STARTUP   = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RESPOND   = 3'd5;

  logic              lock_meta, lock_sync;
  logic [2:0]        state, state_n;
  logic [SC_W-1:0]   su_cnt, su_cnt_n;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
  logic              gnt_bus, gnt_bus_n;
  logic              grant_c, pick_bus;
  logic              ready_n, cpu_ack_n, cpu_err_n, bus_ack_n, bus_err_n, mem_start_n;
  logic [DATA_W-1:0] rdata_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_we_n;
  logic [1:0]        mem_be_n;

  // Two-flop synchroniser for the raw PLL lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  assign grant_c = (state == S_IDLE) && (cpu_req || bus_req) && !mem_busy && lock_sync;

`ifdef RAM_ARB_BUS_PRIORITY_EN
  assign pick_bus = bus_req;
`else
  logic last_bus, last_bus_n;

  // On a tie, grant the side that did not win last time
  assign pick_bus = bus_req && (!cpu_req || !last_bus);

  always_comb begin
    last_bus_n = last_bus;
    if (grant_c) last_bus_n = pick_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) last_bus <= 1'b0;
    else       last_bus <= last_bus_n;
  end
`endif

  always_comb begin
    state_n     = state;
    su_cnt_n    = su_cnt;
    wd_cnt_n    = wd_cnt;
    gnt_bus_n   = gnt_bus;
    cpu_ack_n   = 1'b0;
    cpu_err_n   = 1'b0;
    bus_ack_n   = 1'b0;
    bus_err_n   = 1'b0;
    mem_start_n = 1'b0;
    rdata_n     = rdata;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_be_n    = mem_be;
    case (state)
      S_WAIT_LOCK: begin
        su_cnt_n = '0;
        // The first cycle with lock_sync high already counts toward the startup delay
        if (lock_sync) begin
          state_n  = S_STARTUP;
          su_cnt_n = SC_W'(1);
        end
      end
      S_STARTUP: begin
        if (su_cnt >= SC_W'(STARTUP_CYCLES - 1)) state_n = S_IDLE;
        else                                     su_cnt_n = su_cnt + SC_W'(1);
      end
      S_IDLE: begin
        if (grant_c) begin
          state_n     = S_ISSUE;
          mem_start_n = 1'b1;
          gnt_bus_n   = pick_bus;
          wd_cnt_n    = '0;
          mem_we_n    = pick_bus ? bus_we    : cpu_we;
          mem_addr_n  = pick_bus ? bus_addr  : cpu_addr;
          mem_wdata_n = pick_bus ? bus_wdata : cpu_wdata;
          mem_be_n    = pick_bus ? bus_be    : cpu_be;
        end
      end
      S_ISSUE: begin
        state_n  = S_WAIT_DONE;
        wd_cnt_n = WD_W'(1);
      end
      S_WAIT_DONE: begin
        if (mem_done) begin
          state_n   = S_RESPOND;
          cpu_ack_n = !gnt_bus;
          bus_ack_n = gnt_bus;
          if (!mem_we) rdata_n = mem_rdata;
        end else if (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_n   = S_RESPOND;
          cpu_ack_n = !gnt_bus;
          bus_ack_n = gnt_bus;
          cpu_err_n = !gnt_bus;
          bus_err_n = gnt_bus;
        end else begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      S_RESPOND: state_n = S_IDLE;
      default:   state_n = S_WAIT_LOCK;
    endcase
    // Lock loss abandons any transfer silently; the client keeps its request up
    if (!lock_sync) begin
      state_n     = S_WAIT_LOCK;
      su_cnt_n    = '0;
      cpu_ack_n   = 1'b0;
      cpu_err_n   = 1'b0;
      bus_ack_n   = 1'b0;
      bus_err_n   = 1'b0;
      mem_start_n = 1'b0;
    end
    ready_n = (state_n == S_IDLE) || (state_n == S_ISSUE) ||
              (state_n == S_WAIT_DONE) || (state_n == S_RESPOND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT_LOCK;
      su_cnt    <= '0;
      wd_cnt    <= '0;
      gnt_bus   <= 1'b0;
      ready     <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      mem_start <= 1'b0;
      rdata     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state     <= state_n;
      su_cnt    <= su_cnt_n;
      wd_cnt    <= wd_cnt_n;
      gnt_bus   <= gnt_bus_n;
      ready     <= ready_n;
      cpu_ack   <= cpu_ack_n;
      cpu_err   <= cpu_err_n;
      bus_ack   <= bus_ack_n;
      bus_err   <= bus_err_n;
      mem_start <= mem_start_n;
      rdata     <= rdata_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_be    <= mem_be_n;
    end
  end

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Scoreboard bench for ram_req_arbiter: directed scenarios plus randomized two-client traffic.
module tb_ram_req_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int SC = 16;
  localparam int TO = 8;

  logic          clk, reset, pll_lock, ready;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [1:0]    cpu_be;
  logic          bus_req, bus_we, bus_ack, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [1:0]    bus_be;
  logic [DW-1:0] rdata;
  logic          mem_start, mem_we, mem_busy, mem_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    mem_be;

  ram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARTUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .ready(ready),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err),
    .rdata(rdata), .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          is_bus;
    logic          err;
    logic          chk_rd;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } exp_t;

  typedef struct {
    int            lat;   // mem_done arrives lat clk after mem_start; 0 = never
    logic [DW-1:0] data;
  } plan_t;

  exp_t          exp_q[$];
  plan_t         plan_q[$];
  logic          glog[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            starts = 0;
  int            acks = 0;
  int            done_at = 0;
  logic [DW-1:0] done_data = '0;
  logic [1:0]    req_smp = '0;
  logic          busy_smp = 1'b0;
  logic          last_bus = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  logic          ready_prev = 1'b0;
  logic          cf_we, bf_we;
  logic [AW-1:0] cf_addr, bf_addr;
  logic [DW-1:0] cf_wdata, bf_wdata;
  logic [1:0]    cf_be, bf_be;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_smp  <= {bus_req, cpu_req};
    busy_smp <= mem_busy;
  end

  // Controller model: answers each mem_start per plan and predicts the client-visible response
  always @(negedge clk) begin
    plan_t p;
    exp_t  e;
    logic  eb, f_we;
    mem_done  = 1'b0;
    mem_rdata = DW'($urandom());
    if (done_at != 0 && cyc == done_at) begin
      mem_done  = 1'b1;
      mem_rdata = done_data;
      done_at   = 0;
    end
    if (mem_start) begin
      starts++;
      if (plan_q.size() != 0) p = plan_q.pop_front();
      else begin
        p.lat  = $urandom_range(2, 10);
        p.data = DW'($urandom());
      end
      chk("start_has_req", 32'(req_smp != 2'b00), 1);
      chk("start_not_busy", 32'(busy_smp), 0);
      chk("start_ready", 32'(ready), 1);
`ifdef RAM_ARB_BUS_PRIORITY_EN
      eb = req_smp[1];
`else
      eb = (req_smp == 2'b11) ? !last_bus : req_smp[1];
`endif
      last_bus = eb;
      glog.push_back(eb);
      f_we = eb ? bf_we : cf_we;
      chk("mem_we", 32'(mem_we), 32'(f_we));
      chk("mem_addr", 32'(mem_addr), eb ? 32'(bf_addr) : 32'(cf_addr));
      chk("mem_wdata", 32'(mem_wdata), eb ? 32'(bf_wdata) : 32'(cf_wdata));
      chk("mem_be", 32'(mem_be), eb ? 32'(bf_be) : 32'(cf_be));
      e.is_bus = eb;
      if (p.lat >= 2 && p.lat <= TO) begin
        e.err     = 1'b0;
        e.ack_cyc = cyc + p.lat;
        e.chk_rd  = !f_we;
        if (!f_we) model_rdata = p.data;
      end else begin
        e.err     = 1'b1;
        e.ack_cyc = cyc + TO;
        e.chk_rd  = 1'b1;
      end
      e.rdata = model_rdata;
      exp_q.push_back(e);
      if (p.lat >= 2) begin
        done_at   = cyc + p.lat - 1;
        done_data = p.data;
      end
    end
  end

  // Monitor: pops one expectation per ack; lock loss cancels any transfer in flight
  always @(negedge clk) begin
    exp_t e;
    chk("err_without_ack", 32'((cpu_err & ~cpu_ack) | (bus_err & ~bus_ack)), 0);
    if (ready_prev && !ready) exp_q.delete();
    ready_prev = ready;
    if (cpu_ack || bus_ack) begin
      acks++;
      chk("single_ack", 32'(cpu_ack & bus_ack), 0);
      chk("ack_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ack_client_bus", 32'(bus_ack), 32'(e.is_bus));
        chk("ack_err", 32'(bus_ack ? bus_err : cpu_err), 32'(e.err));
        chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        if (e.chk_rd) chk("ack_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (cpu_ack) cpu_req = 1'b0;
    if (bus_ack) bus_req = 1'b0;
  endtask

  task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] be);
    cf_we = we; cf_addr = a; cf_wdata = d; cf_be = be;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be; cpu_req = 1'b1;
  endtask

  task automatic bus_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] be);
    bf_we = we; bf_addr = a; bf_wdata = d; bf_be = be;
    bus_we = we; bus_addr = a; bus_wdata = d; bus_be = be; bus_req = 1'b1;
  endtask

  task automatic plan(input int lat, input logic [DW-1:0] d);
    plan_t p;
    p.lat = lat;
    p.data = d;
    plan_q.push_back(p);
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n = 0;
    while ((cpu_req || bus_req || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < limit), 1);
  endtask

  task automatic lock_up(input string nm);
    pll_lock = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 17) chk({nm, "_ready_early"}, 32'(ready), 0);
      if (i == 18) chk({nm, "_ready_rise"}, 32'(ready), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int n, a, g0;
    reset = 1'b1; pll_lock = 1'b0; mem_busy = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
    cf_we = 0; cf_addr = '0; cf_wdata = '0; cf_be = '0;
    bf_we = 0; bf_addr = '0; bf_wdata = '0; bf_be = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_acks", 32'({cpu_ack, bus_ack, cpu_err, bus_err, mem_start}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_fields", 32'(mem_addr) | 32'(mem_wdata) | 32'(mem_be), 0);
    reset = 1'b0;

    // Startup gating, then a read with mem_done 5 clk after mem_start
    tick();
    cpu_issue(1'b0, 22'h12345, 16'h0, 2'b11);
    plan(5, 16'hBEEF);
    lock_up("t1");
    #1 chk("t1_no_start_before_ready", 32'(starts), 0);
    wait_idle("t2_done", 100);
    chk("t2_rdata", 32'(rdata), 32'hBEEF);

    // Simultaneous requests, four rounds
    g0 = glog.size();
    for (int r = 0; r < 4; r++) begin
      tick();
      cpu_issue(1'b0, AW'($urandom()), DW'($urandom()), 2'b11);
      bus_issue(1'b1, AW'($urandom()), DW'($urandom()), 2'($urandom()));
      wait_idle("t3_done", 100);
    end
    chk("t3_grants", 32'(glog.size() - g0), 8);
    for (int k = 0; k < 8 && g0 + k < glog.size(); k++)
      chk("t3_grant_order", 32'(glog[g0 + k]), 32'((k % 2) == 0));

    // Bus write times out; late mem_done overlaps the next grant
    tick();
    bus_issue(1'b1, 22'h3ABCD, 16'h5A5A, 2'b01);
    plan(10, 16'hDEAD);
    wait_idle("t4_timeout_done", 100);
    tick();
    cpu_issue(1'b0, 22'h00777, 16'h0, 2'b11);
    plan(3, 16'hC0DE);
    wait_idle("t4_next_done", 100);
    chk("t4_rdata", 32'(rdata), 32'hC0DE);

    // Lock loss during WAIT_DONE, request re-served after new startup
    tick();
    n = starts;
    a = acks;
    cpu_issue(1'b0, 22'h2F00F, 16'h0, 2'b11);
    plan(0, 16'h0);
    for (int g = 0; g < 100 && starts == n; g++) @(posedge clk);
    chk("t5_first_start", 32'(starts), 32'(n + 1));
    tick();
    pll_lock = 1'b0;
    tick(); chk("t5_ready_hold1", 32'(ready), 1);
    tick(); chk("t5_ready_hold2", 32'(ready), 1);
    tick(); chk("t5_ready_drop", 32'(ready), 0);
    repeat (6) tick();
    chk("t5_no_ack", 32'(acks), 32'(a));
    plan(4, 16'h1234);
    lock_up("t5");
    wait_idle("t5_done", 100);
    chk("t5_reissue_once", 32'(starts), 32'(n + 2));
    chk("t5_single_ack", 32'(acks), 32'(a + 1));
    chk("t5_rdata", 32'(rdata), 32'h1234);

    // Controller busy holds off the start
    tick();
    mem_busy = 1'b1;
    n = starts;
    cpu_issue(1'b1, 22'h01010, 16'hF00D, 2'b10);
    repeat (10) tick();
    #1 chk("t6_held_off", 32'(starts), 32'(n));
    tick();
    mem_busy = 1'b0;
    tick();
    #1 chk("t6_start_next_clk", 32'(starts), 32'(n + 1));
    wait_idle("t6_done", 100);

    // Random two-client traffic with random controller latency and busy
    for (int it = 0; it < 1500; it++) begin
      tick();
      mem_busy = ($urandom_range(0, 3) == 0);
      if (!cpu_req && !cpu_ack && $urandom_range(0, 2) == 0)
        cpu_issue(1'($urandom()), AW'($urandom()), DW'($urandom()), 2'($urandom()));
      if (!bus_req && !bus_ack && $urandom_range(0, 2) == 0)
        bus_issue(1'($urandom()), AW'($urandom()), DW'($urandom()), 2'($urandom()));
    end
    tick();
    mem_busy = 1'b0;
    wait_idle("rand_drain", 500);
    chk("rand_some_traffic", 32'(starts > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
